// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu block: FSM states, opcodes, ALU operations,
// interrupt vectoring and opcode classification helpers.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INT_W   = 5;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALUOP_W = 3;

  // FSM state encoding
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t F_ADDR  = 4'd0;
  localparam state_t F_DATA  = 4'd1;
  localparam state_t O1_ADDR = 4'd2;
  localparam state_t O1_DATA = 4'd3;
  localparam state_t O2_ADDR = 4'd4;
  localparam state_t O2_DATA = 4'd5;
  localparam state_t M_ADDR  = 4'd6;
  localparam state_t M_DATA  = 4'd7;
  localparam state_t EXEC    = 4'd8;
  localparam state_t INT     = 4'd9;
  localparam state_t HALT    = 4'd10;

  // Interrupt n vectors to INT_VEC_BASE + 8n
  localparam logic [ADDR_W-1:0] INT_VEC_BASE = 16'hFF00;

  // Opcodes
  localparam logic [DATA_W-1:0] OP_NOP    = 8'h00;
  localparam logic [DATA_W-1:0] OP_LDI_A  = 8'h01;
  localparam logic [DATA_W-1:0] OP_LDI_B  = 8'h02;
  localparam logic [DATA_W-1:0] OP_LDA    = 8'h03;
  localparam logic [DATA_W-1:0] OP_STA    = 8'h04;
  localparam logic [DATA_W-1:0] OP_LDZ    = 8'h05;
  localparam logic [DATA_W-1:0] OP_STZ    = 8'h06;
  localparam logic [DATA_W-1:0] OP_ADD    = 8'h10;
  localparam logic [DATA_W-1:0] OP_SUB    = 8'h11;
  localparam logic [DATA_W-1:0] OP_AND    = 8'h12;
  localparam logic [DATA_W-1:0] OP_OR     = 8'h13;
  localparam logic [DATA_W-1:0] OP_XOR    = 8'h14;
  localparam logic [DATA_W-1:0] OP_MOV_BA = 8'h15;
  localparam logic [DATA_W-1:0] OP_MOV_AB = 8'h16;
  localparam logic [DATA_W-1:0] OP_JMP    = 8'h20;
  localparam logic [DATA_W-1:0] OP_JZ     = 8'h21;
  localparam logic [DATA_W-1:0] OP_JC     = 8'h22;
  localparam logic [DATA_W-1:0] OP_EI     = 8'h30;
  localparam logic [DATA_W-1:0] OP_DI     = 8'h31;
  localparam logic [DATA_W-1:0] OP_RETI   = 8'h32;
  localparam logic [DATA_W-1:0] OP_HLT    = 8'hFF;

  // ALU operations; values match the low bits of opcodes 10..14
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 3'd4;

  // Instructions carrying a 16-bit address operand
  function automatic logic is_abs(input logic [DATA_W-1:0] op);
    return op inside {OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_JC};
  endfunction

  // Data accesses using a 16-bit address
  function automatic logic is_mem_abs(input logic [DATA_W-1:0] op);
    return op inside {OP_LDA, OP_STA};
  endfunction

  // Zero-page data accesses
  function automatic logic is_zp(input logic [DATA_W-1:0] op);
    return op inside {OP_LDZ, OP_STZ};
  endfunction

  function automatic logic is_store(input logic [DATA_W-1:0] op);
    return op inside {OP_STA, OP_STZ};
  endfunction

  // Any instruction that fetches at least one operand byte
  function automatic logic has_operand(input logic [DATA_W-1:0] op);
    return is_abs(op) || is_zp(op) || (op == OP_LDI_A) || (op == OP_LDI_B);
  endfunction

  // Index of the lowest set request bit (bit 0 wins)
  function automatic logic [2:0] int_index(input logic [INT_W-1:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = int'(INT_W) - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [ADDR_W-1:0] int_vector(input logic [2:0] idx);
    return INT_VEC_BASE | ADDR_W'({idx, 3'b000});
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU: add, subtract with borrow, and bitwise logic ops.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] result_o,
  output logic       z_o,
  output logic       c_o
);

  logic [8:0] sum;
  logic [8:0] diff;

  // Result and carry/borrow selection
  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    diff     = {1'b0, a_i} - {1'b0, b_i};
    result_o = a_i;
    c_o      = 1'b0;
    case (op_i)
      ALU_ADD: begin result_o = sum[7:0];  c_o = sum[8];     end
      ALU_SUB: begin result_o = diff[7:0]; c_o = (a_i < b_i); end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      default: result_o = a_i;
    endcase
  end

  assign z_o = (result_o == 8'h00);

endmodule

// File: rtl/cpu.sv
// 8-bit accumulator CPU with two-cycle memory accesses over an external
// MAR/MBR, a shared tri-state data bus and five prioritised interrupts.
module cpu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  int_in,
  output logic        zero_page,
  output logic        mem_part,
  output logic        mem_out,
  output logic        mem_in,
  output logic        reg_mbr_load,
  output logic        reg_mbr_word_dir,
  output logic        reg_mar_load,
  output logic [15:0] addr_bus,
  output logic [4:0]  int_bus,
  inout  wire  [7:0]  data_bus
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] spc_q, spc_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  op_lo_q, op_lo_d;
  logic [7:0]  op_hi_q, op_hi_d;
  logic        z_q, z_d;
  logic        c_q, c_d;
  logic        ie_q, ie_d;
  logic [4:0]  int_bus_q, int_bus_d;
  logic        at_boundary;
  logic        take_int;

  logic [7:0]  alu_res;
  logic        alu_z;
  logic        alu_c;

  logic        addr_cyc;
  logic        data_cyc;
  logic        wr_cyc;
  logic        m_cyc;

  cpu_alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (ir_q[2:0]),
    .result_o (alu_res),
    .z_o      (alu_z),
    .c_o      (alu_c)
  );

  // Next-state, datapath and interrupt-entry logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    spc_d       = spc_q;
    addr_d      = addr_q;
    a_d         = a_q;
    b_d         = b_q;
    ir_d        = ir_q;
    op_lo_d     = op_lo_q;
    op_hi_d     = op_hi_q;
    z_d         = z_q;
    c_d         = c_q;
    ie_d        = ie_q;
    int_bus_d   = '0;
    at_boundary = 1'b0;
    take_int    = 1'b0;

    case (state_q)
      F_ADDR: state_d = F_DATA;
      F_DATA: begin
        ir_d = data_bus;
        pc_d = pc_q + 16'd1;
        if (has_operand(data_bus)) begin
          state_d = O1_ADDR;
          addr_d  = pc_q + 16'd1;
        end else begin
          state_d = EXEC;
        end
      end
      O1_ADDR: state_d = O1_DATA;
      O1_DATA: begin
        op_lo_d = data_bus;
        pc_d    = pc_q + 16'd1;
        if (is_abs(ir_q)) begin
          state_d = O2_ADDR;
          addr_d  = pc_q + 16'd1;
        end else if (is_zp(ir_q)) begin
          state_d = M_ADDR;
          addr_d  = {8'h00, data_bus};
        end else begin
          state_d = EXEC;
        end
      end
      O2_ADDR: state_d = O2_DATA;
      O2_DATA: begin
        op_hi_d = data_bus;
        pc_d    = pc_q + 16'd1;
        if (is_mem_abs(ir_q)) begin
          state_d = M_ADDR;
          addr_d  = {data_bus, op_lo_q};
        end else begin
          state_d = EXEC;
        end
      end
      M_ADDR: state_d = M_DATA;
      M_DATA: begin
        // Loads park the data byte in op_lo; the write itself happens on the bus
        if (!is_store(ir_q)) op_lo_d = data_bus;
        state_d = EXEC;
      end
      EXEC: begin
        case (ir_q)
          OP_LDI_A, OP_LDA, OP_LDZ: begin
            a_d = op_lo_q;
            z_d = (op_lo_q == 8'h00);
          end
          OP_LDI_B: begin
            b_d = op_lo_q;
            z_d = (op_lo_q == 8'h00);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            a_d = alu_res;
            z_d = alu_z;
            c_d = alu_c;
          end
          OP_MOV_BA: b_d = a_q;
          OP_MOV_AB: a_d = b_q;
          OP_JMP:    pc_d = {op_hi_q, op_lo_q};
          OP_JZ:     if (z_q) pc_d = {op_hi_q, op_lo_q};
          OP_JC:     if (c_q) pc_d = {op_hi_q, op_lo_q};
          OP_EI:     ie_d = 1'b1;
          OP_DI:     ie_d = 1'b0;
          OP_RETI: begin
            pc_d = spc_q;
            ie_d = 1'b1;
          end
          default: ;
        endcase
        if (ir_q == OP_HLT) state_d = HALT;
        else                at_boundary = 1'b1;
      end
      INT: begin
        state_d = F_ADDR;
        addr_d  = pc_q;
      end
      HALT: take_int = ie_q && (int_in != 5'd0);
      default: begin
        state_d = F_ADDR;
        addr_d  = pc_q;
      end
    endcase

    // Instruction boundary: either start the next fetch or divert to INT
    if (at_boundary) begin
      take_int = ie_d && (int_in != 5'd0);
      if (!take_int) begin
        state_d = F_ADDR;
        addr_d  = pc_d;
      end
    end

    if (take_int) begin
      state_d   = INT;
      spc_d     = pc_d;
      pc_d      = int_vector(int_index(int_in));
      ie_d      = 1'b0;
      int_bus_d = 5'd1 << int_index(int_in);
    end
  end

  // State and register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= F_ADDR;
      pc_q      <= '0;
      spc_q     <= '0;
      addr_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ir_q      <= '0;
      op_lo_q   <= '0;
      op_hi_q   <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      ie_q      <= 1'b0;
      int_bus_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      spc_q     <= spc_d;
      addr_q    <= addr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ir_q      <= ir_d;
      op_lo_q   <= op_lo_d;
      op_hi_q   <= op_hi_d;
      z_q       <= z_d;
      c_q       <= c_d;
      ie_q      <= ie_d;
      int_bus_q <= int_bus_d;
    end
  end

  // Bus strobes decoded from state; gated by rst so an access aborts at once
  always_comb begin
    addr_cyc = !rst && (state_q inside {F_ADDR, O1_ADDR, O2_ADDR, M_ADDR});
    data_cyc = !rst && (state_q inside {F_DATA, O1_DATA, O2_DATA, M_DATA});
    m_cyc    = !rst && (state_q inside {M_ADDR, M_DATA});
    wr_cyc   = !rst && (state_q == M_DATA) && is_store(ir_q);
  end

  assign reg_mar_load     = addr_cyc;
  assign reg_mbr_load     = data_cyc;
  assign mem_in           = wr_cyc;
  assign mem_out          = data_cyc && !wr_cyc;
  assign reg_mbr_word_dir = wr_cyc;
  assign mem_part         = m_cyc;
  assign zero_page        = m_cyc && is_zp(ir_q);
  assign addr_bus         = addr_q;
  assign int_bus          = int_bus_q;
  assign data_bus         = wr_cyc ? a_q : 8'hzz;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: program/data memory model behind an external MAR,
// write scoreboard, and cycle-accurate checks of bus strobes and state.
module tb_cpu;
  import cpu_pkg::*;

  // Value the bench places on an otherwise undriven data bus
  localparam logic [7:0] PROBE = 8'h3C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  int_in = 5'd0;
  logic        zero_page, mem_part, mem_out, mem_in;
  logic        reg_mbr_load, reg_mbr_word_dir, reg_mar_load;
  logic [15:0] addr_bus;
  logic [4:0]  int_bus;
  wire  [7:0]  data_bus;

  cpu dut (
    .clk              (clk),
    .rst              (rst),
    .int_in           (int_in),
    .zero_page        (zero_page),
    .mem_part         (mem_part),
    .mem_out          (mem_out),
    .mem_in           (mem_in),
    .reg_mbr_load     (reg_mbr_load),
    .reg_mbr_word_dir (reg_mbr_word_dir),
    .reg_mar_load     (reg_mar_load),
    .addr_bus         (addr_bus),
    .int_bus          (int_bus),
    .data_bus         (data_bus)
  );

  always #5 clk = ~clk;

  // Memory model: MAR latched on address cycles, reads driven on mem_out
  logic [7:0]  pmem [0:65535];
  logic [7:0]  dmem [0:65535];
  logic [15:0] mar_q = 16'h0000;
  logic [7:0]  rd_byte;

  always @(posedge clk) if (reg_mar_load) mar_q <= addr_bus;

  assign rd_byte  = mem_part ? dmem[mar_q] : pmem[mar_q];
  assign data_bus = mem_out ? rd_byte : 8'hzz;
  assign data_bus = (!mem_out && !mem_in) ? PROBE : 8'hzz;

  // Completed writes, recorded at the closing edge of each write data cycle
  logic [15:0] wr_addr [0:15];
  logic [7:0]  wr_data [0:15];
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_in && wr_cnt < 16) begin
      wr_addr[wr_cnt] <= mar_q;
      wr_data[wr_cnt] <= data_bus;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  exp_total = 0;
  int  rd_idx    = 0;
  int  tests     = 0;
  int  fails     = 0;

  // Strobe vector: {mar, mbr, dir, mem_out, mem_in, mem_part, zero_page}
  function automatic logic [6:0] strobes();
    return {reg_mar_load, reg_mbr_load, reg_mbr_word_dir, mem_out, mem_in, mem_part, zero_page};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    exp_total++;
  endtask

  task automatic check_writes();
    wr_t e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (rd_idx < wr_cnt) begin
        check("wr_addr", 32'(wr_addr[rd_idx]), 32'(e.addr));
        check("wr_data", 32'(wr_data[rd_idx]), 32'(e.data));
        rd_idx++;
      end else begin
        check("wr_missing", 32'(wr_cnt), 32'(rd_idx + 1));
      end
    end
  endtask

  // Hold reset, clear memories and confirm the reset state
  task automatic reset_and_clear(input string tag);
    rst    = 1'b1;
    int_in = 5'd0;
    for (int i = 0; i < 65536; i++) begin
      pmem[i] = 8'h00;
      dmem[i] = 8'h00;
    end
    tick(2);
    check({tag, "_rst_strobes"}, 32'(strobes()), 32'h0);
    check({tag, "_rst_addr"},    32'(addr_bus), 32'h0);
    check({tag, "_rst_intbus"},  32'(int_bus), 32'h0);
    check({tag, "_rst_bus_hiz"}, 32'(data_bus), 32'(PROBE));
    check({tag, "_rst_state"},   32'(dut.state_q), 32'(F_ADDR));
    check({tag, "_rst_regs"},
          32'({dut.pc_q, dut.a_q, dut.b_q}), 32'h0);
    check({tag, "_rst_flags"},
          32'({dut.spc_q, dut.z_q, dut.c_q, dut.ie_q}), 32'h0);
  endtask

  initial begin
    // LDI A,5; LDI B,3; ADD; HLT
    reset_and_clear("t1");
    pmem[0] = 8'h01; pmem[1] = 8'h05; pmem[2] = 8'h02;
    pmem[3] = 8'h03; pmem[4] = 8'h10; pmem[5] = 8'hFF;
    rst = 1'b0;
    #1;
    check("t1_faddr_strb", 32'(strobes()), 32'b1000000);
    check("t1_faddr_addr", 32'(addr_bus), 32'h0000);
    tick(1);
    check("t1_fdata_strb", 32'(strobes()), 32'b0101000);
    tick(14);
    check("t1_exec15", 32'(dut.state_q), 32'(EXEC));
    tick(1);
    check("t1_halt16", 32'(dut.state_q), 32'(HALT));
    check("t1_halt_strb", 32'(strobes()), 32'h0);
    check("t1_a", 32'(dut.a_q), 32'h08);
    check("t1_zc", 32'({dut.z_q, dut.c_q}), 32'b00);
    check("t1_addr_hold", 32'(addr_bus), 32'h0005);
    int_in = 5'b00001;
    tick(2);
    check("t1_halt_ie0", 32'(dut.state_q), 32'(HALT));
    check("t1_intbus_ie0", 32'(int_bus), 32'h0);

    // ADD overflow to zero, JZ taken, SUB borrow, AND/XOR, JC not taken
    reset_and_clear("t2");
    pmem[0] = 8'h01; pmem[1] = 8'hFF; pmem[2] = 8'h02; pmem[3] = 8'h01;
    pmem[4] = 8'h10; pmem[5] = 8'h21; pmem[6] = 8'h34; pmem[7] = 8'h12;
    pmem[16'h1234] = 8'h11; pmem[16'h1235] = 8'h12; pmem[16'h1236] = 8'h14;
    pmem[16'h1237] = 8'h22; pmem[16'h1238] = 8'h00; pmem[16'h1239] = 8'h20;
    pmem[16'h123A] = 8'hFF;
    rst = 1'b0;
    tick(13);
    check("t2_add_a", 32'(dut.a_q), 32'h00);
    check("t2_add_zc", 32'({dut.z_q, dut.c_q}), 32'b11);
    check("t2_jz_fetch", 32'(addr_bus), 32'h0005);
    tick(7);
    check("t2_jz_state", 32'(dut.state_q), 32'(F_ADDR));
    check("t2_jz_target", 32'(addr_bus), 32'h1234);
    check("t2_jz_strb", 32'(strobes()), 32'b1000000);
    tick(3);
    check("t2_sub", 32'({dut.a_q, dut.z_q, dut.c_q}), 32'({8'hFF, 2'b01}));
    tick(3);
    check("t2_and", 32'({dut.a_q, dut.z_q, dut.c_q}), 32'({8'h01, 2'b00}));
    tick(3);
    check("t2_xor", 32'({dut.a_q, dut.z_q, dut.c_q}), 32'({8'h00, 2'b10}));
    tick(7);
    check("t2_jc_nt_addr", 32'(addr_bus), 32'h123A);
    check("t2_jc_nt_state", 32'(dut.state_q), 32'(F_ADDR));

    // LDI A,5A; STZ 40
    reset_and_clear("t3");
    pmem[0] = 8'h01; pmem[1] = 8'h5A; pmem[2] = 8'h06; pmem[3] = 8'h40; pmem[4] = 8'hFF;
    expect_write(16'h0040, 8'h5A);
    rst = 1'b0;
    tick(9);
    check("t3_maddr_state", 32'(dut.state_q), 32'(M_ADDR));
    check("t3_maddr_addr", 32'(addr_bus), 32'h0040);
    check("t3_maddr_strb", 32'(strobes()), 32'b1000011);
    tick(1);
    check("t3_mdata_strb", 32'(strobes()), 32'b0110111);
    check("t3_mdata_bus", 32'(data_bus), 32'h5A);
    tick(1);
    check("t3_exec_strb", 32'(strobes()), 32'h0);
    check("t3_exec_hiz", 32'(data_bus), 32'(PROBE));
    tick(1);
    check("t3_next_fetch", 32'(addr_bus), 32'h0004);
    check_writes();

    // LDA ABCD with data memory holding 77
    reset_and_clear("t4");
    dmem[16'hABCD] = 8'h77;
    pmem[0] = 8'h03; pmem[1] = 8'hCD; pmem[2] = 8'hAB; pmem[3] = 8'hFF;
    rst = 1'b0;
    tick(6);
    check("t4_maddr_addr", 32'(addr_bus), 32'hABCD);
    check("t4_maddr_strb", 32'(strobes()), 32'b1000010);
    tick(1);
    check("t4_mdata_strb", 32'(strobes()), 32'b0101010);
    check("t4_mdata_bus", 32'(data_bus), 32'h77);
    tick(1);
    check("t4_exec_hiz", 32'(data_bus), 32'(PROBE));
    tick(1);
    check("t4_a", 32'(dut.a_q), 32'h77);
    check("t4_z", 32'(dut.z_q), 32'h0);
    check("t4_fetch_addr", 32'(addr_bus), 32'h0003);
    check("t4_fetch_hiz", 32'(data_bus), 32'(PROBE));

    // EI; NOP (interrupt raised); handler RETI; HLT; wake from HALT
    reset_and_clear("t5");
    pmem[0] = 8'h30; pmem[1] = 8'h00; pmem[2] = 8'hFF; pmem[3] = 8'h00;
    pmem[16'hFF10] = 8'h32; pmem[16'hFF00] = 8'h32;
    rst = 1'b0;
    tick(3);
    check("t5_ei", 32'(dut.ie_q), 32'h1);
    int_in = 5'b10100;
    tick(3);
    check("t5_int_state", 32'(dut.state_q), 32'(INT));
    check("t5_int_bus", 32'(int_bus), 32'b00100);
    check("t5_int_pc", 32'(dut.pc_q), 32'hFF10);
    check("t5_int_ie", 32'(dut.ie_q), 32'h0);
    check("t5_int_spc", 32'(dut.spc_q), 32'h0002);
    check("t5_int_strb", 32'(strobes()), 32'h0);
    int_in = 5'd0;
    tick(1);
    check("t5_vec_fetch", 32'(addr_bus), 32'hFF10);
    check("t5_int_bus_clr", 32'(int_bus), 32'h0);
    tick(3);
    check("t5_reti_addr", 32'(addr_bus), 32'h0002);
    check("t5_reti_ie", 32'(dut.ie_q), 32'h1);
    tick(3);
    check("t5_halt", 32'(dut.state_q), 32'(HALT));
    tick(2);
    check("t5_halt_strb", 32'(strobes()), 32'h0);
    int_in = 5'b00001;
    tick(1);
    check("t5_wake_state", 32'(dut.state_q), 32'(INT));
    check("t5_wake_bus", 32'(int_bus), 32'b00001);
    check("t5_wake_spc", 32'(dut.spc_q), 32'h0003);
    check("t5_wake_pc", 32'(dut.pc_q), 32'hFF00);
    int_in = 5'd0;
    tick(4);
    check("t5_wake_ret", 32'(addr_bus), 32'h0003);

    // Reset during the STA write data cycle
    reset_and_clear("t6");
    pmem[0] = 8'h01; pmem[1] = 8'h99; pmem[2] = 8'h04;
    pmem[3] = 8'h00; pmem[4] = 8'h30; pmem[5] = 8'hFF;
    rst = 1'b0;
    tick(12);
    check("t6_mdata_state", 32'(dut.state_q), 32'(M_DATA));
    check("t6_mdata_in", 32'(mem_in), 32'h1);
    rst = 1'b1;
    #1;
    check("t6_abort_strb", 32'(strobes()), 32'h0);
    check("t6_abort_state", 32'(dut.state_q), 32'(F_ADDR));
    check("t6_abort_addr", 32'(addr_bus), 32'h0000);
    check("t6_abort_hiz", 32'(data_bus), 32'(PROBE));
    tick(2);
    rst = 1'b0;
    #1;
    check("t6_restart_strb", 32'(strobes()), 32'b1000000);
    check("t6_restart_addr", 32'(addr_bus), 32'h0000);
    tick(1);
    check("t6_restart_data", 32'(strobes()), 32'b0101000);
    check("t6_restart_hold", 32'(addr_bus), 32'h0000);

    check_writes();
    check("write_count", 32'(wr_cnt), 32'(exp_total));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 int_in  in  5  interrupt request lines, level-sensitive; bit 0 has highest priority.
REQ-004 zero_page  out  1  high while the current data access uses zero-page addressing (addr_bus[15:8]=0x00).
REQ-005 mem_part  out  1  memory region select: 0 = program memory (fetch and operand bytes), 1 = data memory (load/store).
REQ-006 mem_out  out  1  high when memory drives data_bus (read data cycle).
REQ-007 mem_in  out  1  high when memory captures data_bus (write data cycle).
REQ-008 reg_mbr_load  out  1  high in every data cycle; the external MBR latches the byte on that edge.
REQ-009 reg_mbr_word_dir  out  1  transfer direction: 0 = memory to CPU, 1 = CPU to memory.
REQ-010 reg_mar_load  out  1  high in every address cycle; the external MAR latches addr_bus on that edge.
REQ-011 addr_bus  out  16  memory address; holds its value between accesses.
REQ-012 int_bus  out  5  one-hot acknowledge of the serviced interrupt, high for the single entry cycle.
REQ-013 data_bus  inout  8  shared tri-state bus; the CPU drives it only in write data cycles and is high-Z otherwise.

Function
REQ-014 State: 8-bit registers A and B; 16-bit PC; flags Z and C; interrupt enable IE; 16-bit saved-PC register SPC.
REQ-015 Every memory access is two cycles.
- Address cycle: addr_bus valid, reg_mar_load=1.
- Data cycle: reg_mbr_load=1.
- Read data cycle: mem_out=1, word_dir=0, CPU samples data_bus at the closing edge.
- Write data cycle: mem_in=1, word_dir=1, CPU drives data_bus.
REQ-016 mem_out and mem_in are never high in the same cycle; the CPU never drives data_bus while mem_out=1.
REQ-017 FSM states: F_ADDR, F_DATA, O1_ADDR, O1_DATA, O2_ADDR, O2_DATA, M_ADDR, M_DATA, EXEC, INT, HALT.
REQ-018 Fetch cycles and operand cycles (O1 = low byte or immediate, O2 = high byte) use mem_part=0 and increment PC by 1 per byte; PC wraps from 0xFFFF to 0x0000.
REQ-019 Opcodes:
- 00 NOP.
- 01 LDI A,#imm; 02 LDI B,#imm.
- 03 LDA abs16; 04 STA abs16 (little-endian address).
- 05 LDZ zp8; 06 STZ zp8.
- 10 ADD A=A+B; 11 SUB A=A-B; 12 AND; 13 OR; 14 XOR.
- 15 MOV B,A (B<=A); 16 MOV A,B (A<=B).
- 20 JMP abs16; 21 JZ abs16; 22 JC abs16.
- 30 EI; 31 DI; 32 RETI; FF HLT.
- Any other opcode executes as NOP.
REQ-020 M_ADDR and M_DATA use mem_part=1; zero_page=1 only during the M_ADDR and M_DATA cycles of LDZ and STZ.
REQ-021 Flags:
- ALU ops, LDI, LDA and LDZ set Z from the result.
- ADD sets C to the carry-out of bit 7; SUB sets C to borrow (A<B unsigned).
- Logic ops clear C.
- All results are modulo 256.
REQ-022 A not-taken JZ or JC still fetches both address bytes.
REQ-023 Total cycle counts:
- NOP, ALU, MOV, EI, DI, RETI: 3.
- LDI: 5.
- JMP, JZ, JC: 7.
- LDZ, STZ: 7.
- LDA, STA: 9.
REQ-024 Interrupts are sampled only at instruction boundaries, i.e. on entry to F_ADDR, when IE=1 and int_in≠0.
- Go to INT for 1 cycle: int_bus = one-hot of the lowest set bit n; SPC<=PC; IE<=0; PC<=0xFF00+8n.
- Then continue to F_ADDR.
REQ-025 RETI: PC<=SPC and IE<=1; no nesting (SPC is single-level).
REQ-026 HLT enters HALT: no bus activity, all strobes 0. HALT is left only through an interrupt when IE=1, with SPC = address after HLT.
REQ-027 All strobe outputs are low in EXEC, INT and HALT.

Reset
REQ-028 While rst is high, and immediately on its assertion:
- PC=0x0000; A=B=0; Z=C=IE=0; SPC=0.
- State=F_ADDR; addr_bus=0x0000; all strobes, zero_page, mem_part and int_bus are 0; data_bus is high-Z.
REQ-029 Reset asserted mid-access aborts the access with no write completed; the first fetch from 0x0000 begins on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package cpu_pkg holds the opcode constants, the FSM state enum and the interrupt vector base 0xFF00.
REQ-031 Sub-module cpu_alu: combinational; inputs A, B and operation; outputs result, Z and C. Control and registers stay in cpu.

Verification
REQ-032 Reset then memory holding 01 05 02 03 10 FF -> A=0x08, Z=0, C=0, HALT reached after 16 cycles.
REQ-033 A=0xFF, B=0x01, ADD -> A=0x00, Z=1, C=1; then JZ 0x1234 -> next F_ADDR shows addr_bus=0x1234.
REQ-034 A=0x5A, STZ 0x40 -> M_ADDR shows addr_bus=0x0040, zero_page=1, mem_part=1; M_DATA shows mem_in=1, word_dir=1, data_bus=0x5A.
REQ-035 LDA 0xABCD with data memory returning 0x77 -> A=0x77; data_bus is high-Z whenever mem_out=0 and mem_in=0.
REQ-036 EI; raise int_in=5'b10100 -> INT cycle with int_bus=5'b00100, PC=0xFF10, IE=0; RETI returns to the saved PC with IE=1.
REQ-037 Assert rst during the M_DATA cycle of STA -> mem_in drops at once, no write completes, and fetch restarts at 0x0000.
